// File: rtl/fsi_pkg.sv
// Shared types and constants for the fast-serial transmit path.
// Frame = start bit, DATA_W data bits LSB first, port-select bit.
package fsi_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        DEST
    } fsi_state_e;

endpackage

// File: rtl/fsi_tx_arbiter_if.sv
// Byte-producer handshake bundle for the fast-serial arbiter.
// One valid/data/dest/ready lane per requester.
interface fsi_tx_arbiter_if #(
    parameter int NREQ = 2
);

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_dest;
    logic [NREQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_dest,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_dest,
        output req_ready
    );

endinterface

// File: rtl/fsi_tx_frame.sv
// Serializes one latched byte as a fast-serial frame onto FSDI.
// FSDI is registered one step ahead of the state it belongs to.
module fsi_tx_frame
    import fsi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic              dest,
    input  logic              FSCTS,
    output logic              fsdi,
    output logic              idle,
    output logic              done
);

    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

    fsi_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              dest_q, dest_d;
    logic              fsdi_q, fsdi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dest_q  <= PORT_A;
            fsdi_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dest_q  <= dest_d;
            fsdi_q  <= fsdi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dest_d  = dest_q;
        fsdi_d  = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && FSCTS) begin
                    state_d = START;
                    sh_d    = data;
                    dest_d  = dest;
                    fsdi_d  = 1'b0;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                fsdi_d  = sh_q[0];
                sh_d    = sh_q >> 1;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = DEST;
                    fsdi_d  = dest_q;
                end else begin
                    cnt_d  = cnt_q + 3'd1;
                    fsdi_d = sh_q[0];
                    sh_d   = sh_q >> 1;
                end
            end
            DEST: begin
                state_d = IDLE;
                done    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fsdi = fsdi_q;
    assign idle = (state_q == IDLE);

endmodule

// File: rtl/fsi_tx_arbiter.sv
// Round-robin sharing of the FT2232H fast-serial transmit link.
// Grants one requester per frame while the link is idle and FSCTS is high.
module fsi_tx_arbiter
    import fsi_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fsi_tx_arbiter_if.slave      req,
    input  logic                 FSCTS,
    output logic                 FSDI,
    output logic                 FSCLK,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [CNT_W-1:0]     frame_cnt
);

    logic              idle;
    logic              done;
    logic              found;
    logic              grant;
    logic [2:0]        sel;
    logic [DATA_W-1:0] data_sel;
    logic              dest_sel;

    // Search begins just after the last winner, wrapping to index 0.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        data_sel = '0;
        dest_sel = PORT_A;
        for (int j = 1; j <= NREQ; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req.req_valid[i] &&
                    i == (int'(grant_id) + j) % NREQ) begin
                    found = 1'b1;
                    sel   = 3'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (sel == 3'(i)) begin
                data_sel = req.req_data[8*i +: DATA_W];
                dest_sel = req.req_dest[i];
            end
        end
    end

    assign grant = rst_n && idle && FSCTS && found;

    always_comb begin
        req.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req.req_ready[i] = grant && (sel == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id  <= 3'(NREQ - 1);
            frame_cnt <= '0;
        end else begin
            if (grant) begin
                grant_id <= sel;
            end
            if (done) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    fsi_tx_frame u_frame (
        .clk   (clk),
        .rst_n (rst_n),
        .start (grant),
        .data  (data_sel),
        .dest  (dest_sel),
        .FSCTS (FSCTS),
        .fsdi  (FSDI),
        .idle  (idle),
        .done  (done)
    );

    assign busy  = !idle;
    assign FSCLK = clk;

endmodule

// File: tb/tb_fsi_tx_arbiter.sv
// Bench for fsi_tx_arbiter: directed phases plus random traffic,
// checked every cycle against a queue-based frame model.
module tb_fsi_tx_arbiter;

    localparam int NREQ  = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fscts = 1'b0;
    logic             fsdi;
    logic             fsclk;
    logic             busy;
    logic [2:0]       grant_id;
    logic [CNT_W-1:0] frame_cnt;

    fsi_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    fsi_tx_arbiter #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus),
        .FSCTS     (fscts),
        .FSDI      (fsdi),
        .FSCLK     (fsclk),
        .busy      (busy),
        .grant_id  (grant_id),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q[$];
    int exp_cnt = 0;
    int exp_gid = NREQ - 1;
    int ready_seen = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a pending frame is the queue of FSDI values still to appear.
    task automatic model_check();
        bit          idle;
        bit          last;
        int          exp_fsdi;
        int          new_gid;
        int          d;
        logic [31:0] exp_ready;
        idle      = (q.size() == 0);
        exp_fsdi  = idle ? 1 : q.pop_front();
        last      = !idle && (q.size() == 0);
        exp_ready = '0;
        new_gid   = exp_gid;
        if (idle && rst_n && fscts && (bus.req_valid != '0)) begin
            for (int j = 1; j <= NREQ; j++) begin
                int i;
                i = (exp_gid + j) % NREQ;
                if (new_gid == exp_gid && exp_ready == '0 &&
                    bus.req_valid[i]) begin
                    new_gid      = i;
                    exp_ready[i] = 1'b1;
                end
            end
            d = int'(bus.req_data[8*new_gid +: 8]);
            q.push_back(0);
            for (int k = 0; k < 8; k++) q.push_back((d >> k) & 1);
            q.push_back(int'(bus.req_dest[new_gid]));
        end
        if (bus.req_ready != '0) ready_seen++;
        chk("fsdi", 32'(fsdi), 32'(exp_fsdi));
        chk("busy", 32'(busy), 32'(!idle));
        chk("ready", 32'(bus.req_ready), exp_ready);
        chk("grant_id", 32'(grant_id), 32'(exp_gid));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        exp_gid = new_gid;
        if (last) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic model_reset();
        q.delete();
        exp_cnt = 0;
        exp_gid = NREQ - 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        fscts = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_fsdi", 32'(fsdi), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'(NREQ - 1));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_dest  = '0;
        do_reset();

        // Single frame: 0xA5 to port B
        fscts = 1'b1;
        bus.req_data[7:0] = 8'hA5;
        bus.req_dest[0]   = 1'b1;
        bus.req_valid     = 2'b01;
        cycle();
        bus.req_valid = '0;
        bus.req_data  = '0;
        run(12);
        chk("single_cnt", 32'(frame_cnt), 32'd1);

        // Fair sharing
        bus.req_data  = 16'h3C81;
        bus.req_dest  = 2'b10;
        bus.req_valid = 2'b11;
        run(44);
        bus.req_valid = '0;
        run(12);

        // Flow control
        fscts = 1'b0;
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h00E7;
        run(5);
        fscts = 1'b1;
        cycle();
        bus.req_valid = '0;
        run(4);
        fscts = 1'b0;
        bus.req_valid = 2'b11;
        run(10);
        fscts = 1'b1;
        run(3);
        bus.req_valid = '0;
        run(12);

        // Reset during DATA bit 4
        bus.req_data  = 16'h5A96;
        bus.req_valid = 2'b10;
        cycle();
        bus.req_valid = '0;
        run(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_fsdi", 32'(fsdi), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_cnt", 32'(frame_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        cycle();
        bus.req_valid = '0;
        run(12);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.req_data  = 16'($urandom());
            bus.req_dest  = 2'($urandom_range(0, 3));
            fscts = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.req_valid = '0;
        run(12);

        // Counter wrap after 17 frames
        do_reset();
        ready_seen = 0;
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h00C3;
        run(177);
        bus.req_valid = '0;
        run(12);
        chk("wrap_cnt", 32'(frame_cnt), 32'd1);
        chk("wrap_ready", 32'(ready_seen), 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
